mandel_scan_ctrl: RTL and testbench

- Frame scan controller for the Mandelbrot renderer.
- Walks pixel coordinates (x, y) in raster order over an H_RES x V_RES frame and issues one compute request per pixel to the iteration engine over a valid/ready handshake.
- Accepts the 8-bit colour result and writes it to the framebuffer at linear address x + y*H_RES.
- The address is maintained incrementally with a counter; no multiplier is used.

---
 rtl/mandel_pkg.sv | 21 ++
 rtl/pixel_scan_counter.sv | 63 ++++++
 rtl/mandel_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_mandel_scan_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared frame geometry, bus widths and scan-state encoding for the
// Mandelbrot renderer's scan controller.
package mandel_pkg;

   localparam int H_RES        = 800;
   localparam int V_RES        = 600;
   localparam int FRAME_PIXELS = H_RES * V_RES;

   localparam int COORD_W = 16;
   localparam int ADDR_W  = 19;
   localparam int DATA_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } scan_state_e;

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster-order x/y position plus the matching linear framebuffer address,
// advanced together so no multiplier is needed.
module pixel_scan_counter #(
   parameter int H_RES   = mandel_pkg::H_RES,
   parameter int V_RES   = mandel_pkg::V_RES,
   parameter int COORD_W = mandel_pkg::COORD_W,
   parameter int ADDR_W  = mandel_pkg::ADDR_W
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_clear,
   input  logic               i_advance,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y,
   output logic [ADDR_W-1:0]  o_addr,
   output logic               o_last
);

   localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(H_RES - 1);
   localparam logic [ADDR_W-1:0]  ADDR_MAX = ADDR_W'(H_RES * V_RES - 1);

   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;

   assign o_x    = x_q;
   assign o_y    = y_q;
   assign o_addr = addr_q;
   assign o_last = (addr_q == ADDR_MAX);

   // The final pixel holds its position so y and addr never leave the frame.
   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      addr_d = addr_q;
      if (i_clear) begin
         x_d    = '0;
         y_d    = '0;
         addr_d = '0;
      end else if (i_advance && !o_last) begin
         addr_d = addr_q + 1'b1;
         if (x_q == X_MAX) begin
            x_d = '0;
            y_d = y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         addr_q <= addr_d;
      end
   end

endmodule

// File: rtl/mandel_scan_ctrl.sv
// Frame scan controller: one compute request per pixel in raster order,
// result written to the framebuffer at x + y*H_RES.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for i_start; all strobes low
// ST_ISSUE | request for current pixel held valid until accepted
// ST_WAIT  | result accepted from the engine and latched
// ST_WRITE | one-cycle framebuffer write, then advance position
// ST_DONE  | one-cycle o_done pulse after the last pixel
module mandel_scan_ctrl
   import mandel_pkg::*;
#(
   parameter int H_RES   = mandel_pkg::H_RES,
   parameter int V_RES   = mandel_pkg::V_RES,
   parameter int COORD_W = mandel_pkg::COORD_W,
   parameter int ADDR_W  = mandel_pkg::ADDR_W,
   parameter int DATA_W  = mandel_pkg::DATA_W
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_abort,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_req_valid,
   output logic [COORD_W-1:0] o_req_x,
   output logic [COORD_W-1:0] o_req_y,
   input  logic               i_req_ready,
   input  logic               i_res_valid,
   input  logic [DATA_W-1:0]  i_res_data,
   output logic               o_res_ready,
   output logic               o_wr_en,
   output logic [ADDR_W-1:0]  o_wr_addr,
   output logic [DATA_W-1:0]  o_wr_data
);

   scan_state_e        state_q, state_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               cnt_clear;
   logic               cnt_advance;
   logic               cnt_last;

   pixel_scan_counter #(
      .H_RES   (H_RES),
      .V_RES   (V_RES),
      .COORD_W (COORD_W),
      .ADDR_W  (ADDR_W)
   ) u_counter (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clear   (cnt_clear),
      .i_advance (cnt_advance),
      .o_x       (o_req_x),
      .o_y       (o_req_y),
      .o_addr    (o_wr_addr),
      .o_last    (cnt_last)
   );

   assign o_wr_data = data_q;

   // Abort masks the handshake and write strobes in the same cycle so an
   // aborted pixel never reaches the engine or the framebuffer.
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      cnt_clear   = 1'b0;
      cnt_advance = 1'b0;
      o_busy      = (state_q != ST_IDLE);
      o_req_valid = 1'b0;
      o_res_ready = 1'b0;
      o_wr_en     = 1'b0;
      o_done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start && !i_abort) begin
               cnt_clear = 1'b1;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            o_req_valid = !i_abort;
            if (i_abort)          state_d = ST_IDLE;
            else if (i_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            o_res_ready = !i_abort;
            if (i_abort) begin
               state_d = ST_IDLE;
            end else if (i_res_valid) begin
               data_d  = i_res_data;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            o_wr_en = !i_abort;
            if (i_abort) begin
               state_d = ST_IDLE;
            end else begin
               cnt_advance = 1'b1;
               state_d     = cnt_last ? ST_DONE : ST_ISSUE;
            end
         end
         ST_DONE: begin
            o_done  = !i_abort;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// Bench for mandel_scan_ctrl on a 4x3 frame: an engine model with random
// latencies feeds the DUT, a monitor compares against the raster-order model.
module tb_mandel_scan_ctrl;

   localparam int H     = 4;
   localparam int V     = 3;
   localparam int FRAME = H * V;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_abort = 1'b0;
   logic        i_req_ready = 1'b0;
   logic        i_res_valid = 1'b0;
   logic [7:0]  i_res_data = '0;
   logic        o_busy, o_done, o_req_valid, o_res_ready, o_wr_en;
   logic [15:0] o_req_x, o_req_y;
   logic [18:0] o_wr_addr;
   logic [7:0]  o_wr_data;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // engine configuration
   int data_mode = 0;
   int data_seed = 0;
   int rmax      = 0;
   int res_fixed = 0;
   int rdmax     = 0;
   int spur      = 0;
   int stall_k   = -1;
   int stall_len = 0;

   // engine state
   int eng_k = 0, pend_k = 0, ready_wait = 0, res_wait = 0;
   bit req_new = 1'b1, res_new = 1'b1;

   // monitor / model state
   bit mon_en = 1'b0;
   bit gap_chk = 1'b0;
   int mon_k = 0, wr_k = 0, done_cnt = 0, stall_seen = 0, last_wr_cyc = 0;

   mandel_scan_ctrl #(
      .H_RES   (H),
      .V_RES   (V),
      .COORD_W (16),
      .ADDR_W  (19),
      .DATA_W  (8)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (i_start),
      .i_abort     (i_abort),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_req_valid (o_req_valid),
      .o_req_x     (o_req_x),
      .o_req_y     (o_req_y),
      .i_req_ready (i_req_ready),
      .i_res_valid (i_res_valid),
      .i_res_data  (i_res_data),
      .o_res_ready (o_res_ready),
      .o_wr_en     (o_wr_en),
      .o_wr_addr   (o_wr_addr),
      .o_wr_data   (o_wr_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // colour the engine returns for linear pixel k
   function automatic int pix_data(input int k);
      if (data_mode == 0) return ((k / H) * 16 + (k % H)) & 255;
      return (k * 73 + data_seed) & 255;
   endfunction

   // engine model: drives inputs 1 time unit after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         i_req_ready = 1'b0;
         i_res_valid = 1'b0;
         i_res_data  = '0;
         if (o_req_valid) begin
            if (req_new) begin
               ready_wait = (eng_k == stall_k) ? stall_len : int'($urandom_range(0, rmax));
               req_new = 1'b0;
            end
            if (ready_wait == 0) begin
               i_req_ready = 1'b1;
               req_new = 1'b1;
               res_new = 1'b1;
               pend_k  = eng_k;
               eng_k++;
            end else begin
               ready_wait--;
            end
            if (spur == 2 || (spur == 1 && $urandom_range(0, 1) == 1)) begin
               i_res_valid = 1'b1;
               i_res_data  = 8'hEE;
            end
         end
         if (o_res_ready) begin
            if (res_new) begin
               res_wait = (res_fixed >= 0) ? res_fixed : int'($urandom_range(0, rdmax));
               res_new = 1'b0;
            end
            if (res_wait == 0) begin
               i_res_valid = 1'b1;
               i_res_data  = 8'(pix_data(pend_k));
            end else begin
               res_wait--;
            end
         end
      end
   end

   // monitor: samples on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (o_req_valid) begin
               check_eq("req_x", int'(o_req_x), mon_k % H);
               check_eq("req_y", int'(o_req_y), mon_k / H);
               check_eq("res_ready_in_issue", int'(o_res_ready), 0);
               if (mon_k == stall_k) stall_seen++;
               if (i_req_ready) begin
                  check_eq("addr_at_handshake", int'(o_wr_addr), mon_k);
                  check_eq("one_outstanding", wr_k, mon_k);
                  mon_k++;
               end
            end
            if (o_wr_en) begin
               check_eq("wr_addr", int'(o_wr_addr), wr_k);
               check_eq("wr_data", int'(o_wr_data), pix_data(wr_k));
               if (gap_chk && wr_k > 0) check_eq("wr_gap", cyc - last_wr_cyc, 3);
               last_wr_cyc = cyc;
               wr_k++;
            end
            if (o_done) begin
               check_eq("done_after_last_wr", cyc - last_wr_cyc, 1);
               check_eq("done_wr_count", wr_k, FRAME);
               done_cnt++;
            end
         end
      end
   end

   task automatic new_frame();
      mon_k = 0; wr_k = 0; done_cnt = 0; stall_seen = 0;
      eng_k = 0; req_new = 1'b1; res_new = 1'b1;
   endtask

   task automatic start_frame();
      @(posedge clk); #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_eq({tag, "_done_seen"}, done_cnt, 1);
      check_eq({tag, "_busy_after_done"}, int'(o_busy), 0);
      check_eq({tag, "_writes"}, wr_k, FRAME);
      repeat (3) @(posedge clk);
      #1 check_eq({tag, "_single_done"}, done_cnt, 1);
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_ctrl"}, int'({o_busy, o_done, o_req_valid, o_res_ready, o_wr_en}), 0);
      check_eq({tag, "_req_x"}, int'(o_req_x), 0);
      check_eq({tag, "_req_y"}, int'(o_req_y), 0);
      check_eq({tag, "_wr_addr"}, int'(o_wr_addr), 0);
      check_eq({tag, "_wr_data"}, int'(o_wr_data), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int n;

      // reset and idle
      #12 check_quiet("in_reset");
      @(negedge clk); #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_eq("idle_busy", int'(o_busy), 0);
      end
      check_quiet("after_reset");
      mon_en = 1'b1;

      // full frame, zero-latency engine
      data_mode = 0; rmax = 0; res_fixed = 0; spur = 0; stall_k = -1; gap_chk = 1'b1;
      new_frame(); start_frame(); wait_done("full", 200);

      // backpressure at pixel (2,1)
      gap_chk = 1'b0; stall_k = 1 * H + 2; stall_len = 5;
      new_frame(); start_frame(); wait_done("stall", 300);
      check_eq("stall_req_cycles", stall_seen, 6);
      stall_k = -1;

      // slow engine with spurious results during ISSUE
      res_fixed = 7; spur = 2;
      new_frame(); start_frame(); wait_done("slow", 400);

      // randomized engine timing and data
      for (int f = 0; f < 3; f++) begin
         data_mode = 1; data_seed = int'($urandom_range(0, 255));
         rmax = 3; res_fixed = -1; rdmax = 4; spur = 1;
         new_frame(); start_frame(); wait_done("rand", 600);
      end

      // abort in WAIT at pixel 5
      data_mode = 0; rmax = 0; res_fixed = 3; spur = 0;
      new_frame(); start_frame();
      found = 1'b0; n = 0;
      while (!found && n < 200) begin
         @(negedge clk);
         n++;
         if (o_res_ready && mon_k == 6) found = 1'b1;
      end
      check_eq("abort_point_found", int'(found), 1);
      i_abort = 1'b1;
      @(posedge clk); #1 i_abort = 1'b0;
      check_eq("abort_busy", int'(o_busy), 0);
      check_eq("abort_hold_addr", int'(o_wr_addr), 5);
      check_eq("abort_hold_x", int'(o_req_x), 1);
      check_eq("abort_hold_y", int'(o_req_y), 1);
      check_eq("abort_hold_data", int'(o_wr_data), 16);
      repeat (5) @(posedge clk);
      #1;
      check_eq("abort_no_write", wr_k, 5);
      check_eq("abort_no_done", done_cnt, 0);
      check_eq("abort_stays_idle", int'(o_busy), 0);

      // abort beats start in IDLE
      new_frame();
      @(posedge clk); #1 begin i_start = 1'b1; i_abort = 1'b1; end
      @(posedge clk); #1 begin i_start = 1'b0; i_abort = 1'b0; end
      check_eq("abort_over_start", int'(o_busy), 0);

      // restart from pixel 0
      res_fixed = 0;
      start_frame();
      check_eq("restart_valid", int'(o_req_valid), 1);
      check_eq("restart_addr", int'(o_wr_addr), 0);
      check_eq("restart_x", int'(o_req_x), 0);
      check_eq("restart_y", int'(o_req_y), 0);
      wait_done("restart", 200);

      // asynchronous reset during the write of pixel 9
      new_frame(); start_frame();
      found = 1'b0; n = 0;
      while (!found && n < 200) begin
         @(negedge clk);
         n++;
         if (o_wr_en && o_wr_addr == 19'd9) found = 1'b1;
      end
      check_eq("reset_point_found", int'(found), 1);
      #2 rst_n = 1'b0;
      #1 check_quiet("mid_reset");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("post_reset_busy", int'(o_busy), 0);
      end
      check_eq("post_reset_writes", wr_k, 10);
      check_quiet("post_reset");

      // recovery frame after reset
      data_mode = 1; data_seed = int'($urandom_range(0, 255));
      rmax = 2; res_fixed = -1; rdmax = 2; spur = 1;
      new_frame(); start_frame(); wait_done("recover", 500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
